// File: rtl/scie_issue_queue.sv
// SCIE command queue: buffers core commands and issues one per cycle to the FIR unit, spacing READ after PUSH.
// Accept-to-issue latency >= 1 cycle; io_cmd_ready low only when full; io_stall or PUSH->READ spacing holds the head.
module scie_issue_queue #(
  parameter int DEPTH            = 4,
  parameter int XLEN             = 32,
  parameter int PUSH_TO_READ_GAP = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_cmd_valid,
  output logic                   io_cmd_ready,
  input  logic [XLEN-1:0]        io_cmd_insn,
  input  logic [XLEN-1:0]        io_cmd_rs1,
  input  logic [XLEN-1:0]        io_cmd_rs2,
  input  logic                   io_stall,
  output logic                   io_scie_valid,
  output logic [XLEN-1:0]        io_scie_insn,
  output logic [XLEN-1:0]        io_scie_rs1,
  output logic [XLEN-1:0]        io_scie_rs2,
  input  logic [XLEN-1:0]        io_scie_rd,
  output logic                   io_resp_valid,
  output logic [XLEN-1:0]        io_resp_rd,
  output logic [$clog2(DEPTH):0] io_count,
  output logic                   io_illegal
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (PUSH_TO_READ_GAP > 1) ? $clog2(PUSH_TO_READ_GAP) : 1;

  localparam logic [6:0]    OP_COEF  = 7'h0B;
  localparam logic [6:0]    OP_PUSH  = 7'h2B;
  localparam logic [6:0]    OP_READ  = 7'h5B;
  localparam logic [GW-1:0] GAP_LOAD = GW'(PUSH_TO_READ_GAP - 1);

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          resp_vld_q, resp_vld_d;
  logic          illegal_q, illegal_d;

  cmd_t       head;
  logic [6:0] head_op;
  logic [6:0] cmd_op;
  logic       cmd_legal;
  logic       cmd_ready;
  logic       accept;
  logic       enq;
  logic       issue;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_op   = head.insn[6:0];
    cmd_op    = io_cmd_insn[6:0];
    cmd_legal = (cmd_op == OP_COEF) || (cmd_op == OP_PUSH) || (cmd_op == OP_READ);
    // Ready is purely occupancy based; a same-cycle pop never frees a slot early.
    cmd_ready = (count_q != CW'(DEPTH));
    accept    = io_cmd_valid && cmd_ready;
    enq       = accept && cmd_legal;
    issue     = (count_q != '0) && !io_stall && !((head_op == OP_READ) && (gap_q != '0));
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{insn: io_cmd_insn, rs1: io_cmd_rs1, rs2: io_cmd_rs2};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    gap_d = gap_q;
    if (issue && (head_op == OP_PUSH)) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    resp_vld_d = issue && (head_op == OP_READ);
    illegal_d  = accept && !cmd_legal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      resp_vld_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      resp_vld_q <= resp_vld_d;
      illegal_q  <= illegal_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign io_cmd_ready  = cmd_ready;
  assign io_scie_valid = issue;
  assign io_scie_insn  = issue ? head.insn : '0;
  assign io_scie_rs1   = issue ? head.rs1  : '0;
  assign io_scie_rs2   = issue ? head.rs2  : '0;
  assign io_resp_valid = resp_vld_q;
  assign io_resp_rd    = resp_vld_q ? io_scie_rd : '0;
  assign io_count      = count_q;
  assign io_illegal    = illegal_q;

endmodule

// File: tb/tb_scie_issue_queue.sv
// Bench for scie_issue_queue: random and directed traffic against a queue-level reference model,
// with a small FIR unit model attached to the issue port.
module tb_scie_issue_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int GAP   = 2;
  localparam logic [6:0] OP_COEF = 7'h0B;
  localparam logic [6:0] OP_PUSH = 7'h2B;
  localparam logic [6:0] OP_READ = 7'h5B;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } cmd_t;

  logic             clock;
  logic             reset;
  logic             io_cmd_valid;
  logic             io_cmd_ready;
  logic [XLEN-1:0]  io_cmd_insn;
  logic [XLEN-1:0]  io_cmd_rs1;
  logic [XLEN-1:0]  io_cmd_rs2;
  logic             io_stall;
  logic             io_scie_valid;
  logic [XLEN-1:0]  io_scie_insn;
  logic [XLEN-1:0]  io_scie_rs1;
  logic [XLEN-1:0]  io_scie_rs2;
  logic [XLEN-1:0]  io_scie_rd;
  logic             io_resp_valid;
  logic [XLEN-1:0]  io_resp_rd;
  logic [2:0]       io_count;
  logic             io_illegal;

  scie_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PUSH_TO_READ_GAP(GAP)) dut (
    .clock(clock), .reset(reset),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_insn(io_cmd_insn), .io_cmd_rs1(io_cmd_rs1), .io_cmd_rs2(io_cmd_rs2),
    .io_stall(io_stall),
    .io_scie_valid(io_scie_valid), .io_scie_insn(io_scie_insn),
    .io_scie_rs1(io_scie_rs1), .io_scie_rs2(io_scie_rs2), .io_scie_rd(io_scie_rd),
    .io_resp_valid(io_resp_valid), .io_resp_rd(io_resp_rd),
    .io_count(io_count), .io_illegal(io_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain queue plus "cycle of last PUSH issue" for the spacing rule.
  cmd_t        mq[$];
  int          m_last_push = -1000;
  bit          m_resp = 1'b0;
  logic [31:0] m_resp_rd = '0;
  bit          m_ill = 1'b0;
  int          cyc_n = 0;

  // FIR state: index 0 follows the reference model, index 1 follows what the DUT really issued.
  int fc[2][5];
  int fx[2][5];

  int          iss_cnt = 0;
  int          il_cnt = 0;
  int          push_iss_c = 0;
  int          read_iss_c = 0;
  logic [31:0] last_resp = '0;
  logic [2:0]  obs_count;
  logic        obs_ready;
  logic        obs_resp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic void fir_apply(input int m, input cmd_t c);
    int idx;
    idx = int'(c.rs2);
    case (c.insn[6:0])
      OP_COEF: if (idx >= 0 && idx < 5) fc[m][idx] = int'(c.rs1);
      OP_PUSH: begin
        for (int i = 4; i > 0; i--) fx[m][i] = fx[m][i-1];
        fx[m][0] = int'(c.rs1);
      end
      default: ;
    endcase
  endfunction

  function automatic int fir_sum(input int m);
    int s;
    s = 0;
    for (int i = 0; i < 5; i++) s += fc[m][i] * fx[m][i];
    return s;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op);
    logic [31:0] w;
    w      = $urandom();
    w[6:0] = op;
    return w;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [6:0] bad [4];
    int k;
    bad = '{7'h33, 7'h13, 7'h00, 7'h7F};
    k = $urandom_range(0, 9);
    if (k < 3)      return mk(OP_COEF);
    else if (k < 6) return mk(OP_PUSH);
    else if (k < 9) return mk(OP_READ);
    else            return mk(bad[$urandom_range(0, 3)]);
  endfunction

  function automatic bit is_legal(input logic [31:0] insn);
    return insn[6:0] == OP_COEF || insn[6:0] == OP_PUSH || insn[6:0] == OP_READ;
  endfunction

  // One clock cycle: drive at negedge, check #1 later, advance model and unit at posedge.
  task automatic cyc(input bit v, input logic [31:0] insn, input logic [31:0] rs1,
                     input logic [31:0] rs2, input bit st, input bit rst);
    bit   m_iss, acc, d_iss;
    cmd_t e, h, d_cmd;
    io_cmd_valid = v;
    io_cmd_insn  = insn;
    io_cmd_rs1   = rs1;
    io_cmd_rs2   = rs2;
    io_stall     = st;
    reset        = rst;
    #1;
    m_iss = 1'b0;
    e     = '0;
    if (!rst && mq.size() != 0 && !st) begin
      if (mq[0].insn[6:0] != OP_READ || (cyc_n - m_last_push) >= GAP) begin
        m_iss = 1'b1;
        e     = mq[0];
      end
    end
    obs_count = io_count;
    obs_ready = io_cmd_ready;
    obs_resp  = io_resp_valid;
    if (!rst) begin
      chk("ready", io_cmd_ready, mq.size() != DEPTH);
      chk("count", io_count, mq.size());
      chk("scie_valid", io_scie_valid, m_iss);
      chk("scie_insn", io_scie_insn, e.insn);
      chk("scie_rs1", io_scie_rs1, e.rs1);
      chk("scie_rs2", io_scie_rs2, e.rs2);
      chk("resp_valid", io_resp_valid, m_resp);
      chk("resp_rd", io_resp_rd, m_resp ? m_resp_rd : 32'd0);
      chk("illegal", io_illegal, m_ill);
      if (io_illegal) il_cnt++;
      if (io_resp_valid) last_resp = io_resp_rd;
    end
    d_iss = io_scie_valid && !rst;
    d_cmd = '{insn: io_scie_insn, rs1: io_scie_rs1, rs2: io_scie_rs2};
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_resp      = 1'b0;
      m_ill       = 1'b0;
      m_last_push = -1000;
    end else begin
      acc    = v && (mq.size() != DEPTH);
      m_resp = 1'b0;
      m_ill  = 1'b0;
      if (m_iss) begin
        h = mq.pop_front();
        fir_apply(0, h);
        if (h.insn[6:0] == OP_PUSH) m_last_push = cyc_n;
        if (h.insn[6:0] == OP_READ) begin
          m_resp    = 1'b1;
          m_resp_rd = fir_sum(0);
        end
      end
      if (acc) begin
        if (is_legal(insn)) mq.push_back('{insn: insn, rs1: rs1, rs2: rs2});
        else                m_ill = 1'b1;
      end
    end
    // Attached unit: result appears the cycle after a READ, noise otherwise.
    io_scie_rd = $urandom();
    if (d_iss) begin
      iss_cnt++;
      fir_apply(1, d_cmd);
      if (d_cmd.insn[6:0] == OP_PUSH) push_iss_c = cyc_n;
      if (d_cmd.insn[6:0] == OP_READ) begin
        read_iss_c = cyc_n;
        io_scie_rd = fir_sum(1);
      end
    end
    cyc_n++;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) cyc(1'b0, mk(OP_COEF), $urandom(), $urandom(), st, 1'b0);
  endtask

  initial begin
    int coefs [5];
    int il0, iss0;
    coefs = '{-84, -95, -11, -33, -65};
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++) begin
        fc[m][i] = 0;
        fx[m][i] = 0;
      end
    reset = 1'b1; io_cmd_valid = 1'b0; io_cmd_insn = '0; io_cmd_rs1 = '0;
    io_cmd_rs2 = '0; io_stall = 1'b0; io_scie_rd = '0;
    @(negedge clock);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("rst_count", obs_count, 0);
    chk("rst_ready", obs_ready, 1);

    // Coefficient load, one sample, read.
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(OP_COEF), coefs[i], i, 1'b0, 1'b0);
    chk("stream_count", obs_count, 1);
    cyc(1'b1, mk(OP_PUSH), -2, '0, 1'b0, 1'b0);
    cyc(1'b1, mk(OP_READ), '0, '0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t1_gap", read_iss_c - push_iss_c, 2);
    chk("t1_rd", last_resp, 32'd168);

    // Back-to-back PUSH then READ.
    cyc(1'b1, mk(OP_PUSH), -27, '0, 1'b0, 1'b0);
    cyc(1'b1, mk(OP_READ), '0, '0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t2_gap", read_iss_c - push_iss_c, 2);
    chk("t2_rd", last_resp, 32'd2458);

    // Fill under stall, fifth offer refused, then drain and refill across the wrap.
    iss0 = iss_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(OP_COEF), $urandom(), 7, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("t3_count", obs_count, 4);
    chk("t3_ready", obs_ready, 0);
    idle(4, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? mk(OP_PUSH) : mk(OP_COEF), $urandom(), 7, 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("t3_issued", iss_cnt - iss0, 10);
    chk("t3_empty", obs_count, 0);

    // Steady stream of COEFs.
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(OP_COEF), $urandom(), 7, 1'b0, 1'b0);
    chk("t4_count", obs_count, 1);
    idle(2, 1'b0);

    // Illegal opcode.
    il0 = il_cnt; iss0 = iss_cnt;
    cyc(1'b1, 32'h0000_0033, $urandom(), $urandom(), 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t5_ill", il_cnt - il0, 1);
    chk("t5_iss", iss_cnt - iss0, 0);
    chk("t5_count", obs_count, 0);

    // Reset while a READ is at the head and issuing, two more entries behind it.
    cyc(1'b1, mk(OP_READ), '0, '0, 1'b1, 1'b0);
    cyc(1'b1, mk(OP_COEF), $urandom(), 7, 1'b1, 1'b0);
    cyc(1'b1, mk(OP_COEF), $urandom(), 7, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("t6_pre", obs_count, 3);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("t6_count", obs_count, 0);
    chk("t6_resp", obs_resp, 0);
    chk("t6_ready", obs_ready, 1);
    idle(2, 1'b0);

    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) != 0, rand_insn(), $urandom(), $urandom_range(0, 6),
          $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    idle(12, 1'b0);
    chk("drain", obs_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scie_issue_queue.md
Name:
scie_issue_queue

Overview:
- Upstream feeder for the SCIEPipelined custom-instruction unit (FIR-style coefficient-load / sample-push / result-read).
- Buffers SCIE commands from the core in a small FIFO with a valid/ready handshake.
- Decodes the opcode class and enforces the push-to-read spacing that the unit requires.
- Issues one command per cycle on the unit's io_valid/io_insn/io_rs1/io_rs2, and returns io_rd to the core with a response-valid strobe.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- XLEN, 32, width of insn/rs1/rs2/rd.
- PUSH_TO_READ_GAP, 2, minimum cycles from a push issue to a read issue.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- io_cmd_valid  in  1  core presents command.
- io_cmd_ready  out  1  queue can accept; equals (count != DEPTH).
- io_cmd_insn  in  XLEN  instruction word.
- io_cmd_rs1  in  XLEN  operand 1.
- io_cmd_rs2  in  XLEN  operand 2.
- io_stall  in  1  core hold; suppresses issue while high.
- io_scie_valid  out  1  to unit io_valid.
- io_scie_insn  out  XLEN  to unit io_insn.
- io_scie_rs1  out  XLEN  to unit io_rs1.
- io_scie_rs2  out  XLEN  to unit io_rs2.
- io_scie_rd  in  XLEN  from unit io_rd.
- io_resp_valid  out  1  read result available.
- io_resp_rd  out  XLEN  read result.
- io_count  out  log2(DEPTH)+1  current occupancy.
- io_illegal  out  1  one-cycle pulse: unrecognised opcode was dropped.

Behaviour:
- Decode on insn[6:0]:
  - 0x0B = COEF (load coefficient).
  - 0x2B = PUSH (push sample).
  - 0x5B = READ (read result).
  - Anything else is illegal.
- Accept: a command is accepted when io_cmd_valid && io_cmd_ready.
  - Legal commands are enqueued as {insn, rs1, rs2}.
  - Illegal commands are consumed and not enqueued; io_illegal is registered high the next cycle, for exactly one cycle.
- Minimum latency is 1 cycle: an entry accepted in cycle t can issue no earlier than t+1. There is no combinational bypass.
- Issue condition (combinational): count != 0 && !io_stall && !(head is READ && gap_cnt != 0).
  - When the condition holds, io_scie_valid = 1, head fields drive io_scie_*, and the head pops at the clock edge.
  - Otherwise io_scie_valid = 0 and io_scie_insn/rs1/rs2 = 0.
- gap_cnt:
  - Loaded with PUSH_TO_READ_GAP-1 on a PUSH issue.
  - Otherwise decrements toward 0 each cycle, saturating at 0.
  - Only READ is blocked; COEF and PUSH are never blocked.
  - With the default gap: PUSH issued at t, READ can issue at t+2 at the earliest.
- Response:
  - io_resp_valid is registered and equals "READ issued in the previous cycle".
  - io_resp_rd = io_scie_rd while io_resp_valid is high, otherwise 0.
- Simultaneous enqueue and dequeue in the same cycle: both happen and count is unchanged.
- Full and empty:
  - When full, ready is low, so no enqueue happens even if a pop occurs that cycle (ready does not look ahead).
  - When empty, no issue.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; a blocked READ also blocks all younger commands.
- Reset (including mid-operation):
  - count, pointers and gap_cnt are cleared to 0; io_resp_valid and io_illegal go to 0; queued entries are discarded.
  - Outputs after reset: io_cmd_ready = 1, io_scie_valid = 0, io_count = 0.
  - A response pending at reset is dropped.

Test Plan:
- Load and read: COEF (rs2=0..4, rs1 = -84, -95, -11, -33, -65), then PUSH rs1=-2, then READ. Unit attached or modelled.
  -> Issues in order; the READ issues 2 cycles after the PUSH; io_resp_valid pulses with io_resp_rd = 168.
- Back-to-back PUSH rs1=-27 then READ, offered on consecutive cycles.
  -> The READ is held for one cycle (io_scie_valid = 0 in that cycle); io_resp_rd = 2458.
- Full and wrap: io_stall=1, offer 5 commands.
  -> 4 accepted; io_cmd_ready = 0 and io_count = 4.
  -> Release stall: 4 issues in order. Refill with 6 more to exercise pointer wrap; order is preserved.
- Simultaneous enqueue/dequeue: hold io_cmd_valid = 1 with a stream of COEFs, no stall.
  -> io_count stays at 1; one issue per cycle.
- Illegal: insn = 0x33.
  -> Accepted, io_illegal pulses for one cycle, never issued, io_count unchanged.
- Reset mid-stream: 3 entries queued and a READ's response pending, then assert reset for one cycle.
  -> io_count = 0, no issue and no io_resp_valid afterwards, io_cmd_ready = 1.
